// File: rtl/clock_cnt_pkg.sv
// Shared types and helpers for the BCD digit-chain counter.
// Optional build macro used by the design files: CNT_DOWN_EN (count-down mode).
package clock_cnt_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Largest value a mod-M digit can hold.
  function automatic bcd_digit_t digit_max(input bcd_digit_t mod);
    return mod - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_chain_counter_if.sv
// Control/data bundle of the BCD digit-chain counter; master drives the controls,
// slave is the counter itself.
interface bcd_digit_chain_counter_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    en;
  logic                    cin;
  logic                    clr;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    up_dn;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    co_la;
  logic                    cout;
  logic                    load_err;

  modport master (
    output en, cin, clr, load, load_val, up_dn,
    input  count, co_la, cout, load_err
  );

  modport slave (
    input  en, cin, clr, load, load_val, up_dn,
    output count, co_la, cout, load_err
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One mod-MOD BCD digit with clear, sanitised load and step.
// Build macro CNT_DOWN_EN adds decrement (up_dn=0); without it up_dn is ignored.
module bcd_digit_cell
  import clock_cnt_pkg::*;
#(
  parameter bcd_digit_t MOD = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_in,
  input  logic       up_dn,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t ld_val,
  output bcd_digit_t value,
  output logic       at_term,
  output logic       ld_bad
);

  localparam bcd_digit_t MAX = digit_max(MOD);

  bcd_digit_t nxt_step;

  assign ld_bad = (ld_val >= MOD);

`ifdef CNT_DOWN_EN
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    at_term  = 1'b0;
    nxt_step = value;
    if (up_dn) begin
      at_term  = (value == MAX);
      nxt_step = at_term ? '0 : value + 4'd1;
    end else begin
      at_term  = (value == '0);
      nxt_step = at_term ? MAX : value - 4'd1;
    end
  end
`else
  logic unused_up_dn;
  assign unused_up_dn = up_dn;

  always_comb begin
    at_term  = (value == MAX);
    nxt_step = at_term ? '0 : value + 4'd1;
  end
`endif

  // NOTE: state registers use non-blocking assignment so all digits update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= ld_bad ? '0 : ld_val;
    end else if (step_in) begin
      value <= nxt_step;
    end
  end

endmodule

// File: rtl/bcd_digit_chain_counter.sv
// Multi-digit BCD counter with per-digit modulus, lookahead carry and wrap pulse.
// Build macro CNT_DOWN_EN enables count-down mode via up_dn.
module bcd_digit_chain_counter
  import clock_cnt_pkg::*;
#(
  parameter int                              NUM_DIGITS = 2,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0]   DIGIT_MOD  = {4'd6, 4'd10}
) (
  input logic                       clk,
  input logic                       rst,
  bcd_digit_chain_counter_if.slave  bus
);

  logic                  step;
  logic [NUM_DIGITS:0]   lower_term;
  logic [NUM_DIGITS-1:0] at_term;
  logic [NUM_DIGITS-1:0] ld_bad;

  assign step          = bus.en & bus.cin;
  assign lower_term[0] = 1'b1;

  // Digit k steps only when every lower digit sits at its terminal value.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit_cell #(
      .MOD (DIGIT_MOD[k*DIGIT_W +: DIGIT_W])
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .step_in (step & lower_term[k]),
      .up_dn   (bus.up_dn),
      .clr     (bus.clr),
      .load    (bus.load),
      .ld_val  (bus.load_val[k*DIGIT_W +: DIGIT_W]),
      .value   (bus.count[k*DIGIT_W +: DIGIT_W]),
      .at_term (at_term[k]),
      .ld_bad  (ld_bad[k])
    );

    assign lower_term[k+1] = lower_term[k] & at_term[k];
  end

  // Same-edge cascade: feed co_la into the next counter's cin.
  assign bus.co_la = step & lower_term[NUM_DIGITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cout     <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      bus.cout     <= bus.co_la & ~bus.clr & ~bus.load;
      bus.load_err <= bus.load & ~bus.clr & (|ld_bad);
    end
  end

endmodule

// File: tb/tb_bcd_digit_chain_counter.sv
// Directed plus random bench for the default mod-60 counter against an integer model;
// a second instance cascaded through co_la checks same-edge rollover.
module tb_bcd_digit_chain_counter;

  localparam int ND    = 2;
  localparam int UMOD  = 10;
  localparam int TMOD  = 6;
  localparam int TOTAL = UMOD * TMOD;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int   mv;
  bit   m_cout;
  bit   m_lerr;

  always #5 clk = ~clk;

  bcd_digit_chain_counter_if #(.NUM_DIGITS(ND)) if_a  ();
  bcd_digit_chain_counter_if #(.NUM_DIGITS(ND)) if_hi ();

  bcd_digit_chain_counter #(.NUM_DIGITS(ND), .DIGIT_MOD(8'h6A)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  bcd_digit_chain_counter #(.NUM_DIGITS(ND), .DIGIT_MOD(8'h6A)) u_hi (
    .clk (clk),
    .rst (rst),
    .bus (if_hi)
  );

  assign if_hi.cin = if_a.co_la;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / UMOD);
    u = 4'(v % UMOD);
    return {t, u};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle from a negedge: drive, check co_la, advance model, check registered outputs.
  task automatic cyc(input bit e, input bit c, input bit cl, input bit ld, input bit ud,
                     input logic [7:0] lv);
    bit down;
    bit stp;
    bit term;
    int u;
    int t;
    if_a.en = e; if_a.cin = c; if_a.clr = cl; if_a.load = ld;
    if_a.up_dn = ud; if_a.load_val = lv;
    #1;
`ifdef CNT_DOWN_EN
    down = !ud;
`else
    down = 1'b0;
`endif
    stp  = e && c;
    term = down ? (mv == 0) : (mv == TOTAL - 1);
    check("co_la", {31'd0, if_a.co_la}, {31'd0, stp && term});
    if (cl) begin
      mv = 0; m_cout = 0; m_lerr = 0;
    end else if (ld) begin
      u = int'(lv[3:0]);
      t = int'(lv[7:4]);
      m_lerr = (u >= UMOD) || (t >= TMOD);
      if (u >= UMOD) u = 0;
      if (t >= TMOD) t = 0;
      mv = t * UMOD + u;
      m_cout = 0;
    end else begin
      m_lerr = 0;
      m_cout = stp && term;
      if (stp) mv = down ? (mv + TOTAL - 1) % TOTAL : (mv + 1) % TOTAL;
    end
    @(posedge clk);
    @(negedge clk);
    check("count", {24'd0, if_a.count}, {24'd0, to_bcd(mv)});
    check("cout", {31'd0, if_a.cout}, {31'd0, m_cout});
    check("load_err", {31'd0, if_a.load_err}, {31'd0, m_lerr});
  endtask

  initial begin
    rst = 1'b1;
    if_a.en = 0; if_a.cin = 0; if_a.clr = 0; if_a.load = 0; if_a.up_dn = 1; if_a.load_val = '0;
    if_hi.en = 0; if_hi.clr = 0; if_hi.load = 0; if_hi.up_dn = 1; if_hi.load_val = '0;
    mv = 0; m_cout = 0; m_lerr = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset_count", {24'd0, if_a.count}, 32'd0);
    check("reset_cout", {31'd0, if_a.cout}, 32'd0);
    check("reset_load_err", {31'd0, if_a.load_err}, 32'd0);
    rst = 1'b0;

    // Asynchronous reset in the middle of counting at 37.
    cyc(0, 0, 0, 1, 1, 8'h36);
    cyc(1, 1, 0, 0, 1, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", {24'd0, if_a.count}, 32'd0);
    check("async_rst_cout", {31'd0, if_a.cout}, 32'd0);
    check("async_rst_load_err", {31'd0, if_a.load_err}, 32'd0);
    @(negedge clk);
    check("rst_held_count", {24'd0, if_a.count}, 32'd0);
    rst = 1'b0;
    mv = 0; m_cout = 0; m_lerr = 0;

    // Full mod-60 revolution plus the wrap edge.
    for (int i = 0; i < TOTAL + 1; i++) cyc(1, 1, 0, 0, 1, 8'h00);

    // Out-of-range load sanitised to zero, then a valid load.
    cyc(0, 0, 0, 1, 1, 8'h7C);
    cyc(0, 0, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h45);

    // Priority: clr over load over step.
    cyc(0, 0, 0, 1, 1, 8'h22);
    cyc(1, 1, 1, 1, 1, 8'h45);
    cyc(0, 0, 0, 1, 1, 8'h22);
    cyc(1, 1, 0, 1, 1, 8'h10);

    // Enable low at the terminal value holds everything.
    cyc(0, 0, 0, 1, 1, 8'h59);
    cyc(0, 1, 0, 0, 1, 8'h00);

    // Cascade two counters: 59:59 -> 00:00 on one edge.
    if_hi.load = 1; if_hi.load_val = 8'h59;
    cyc(0, 0, 0, 1, 1, 8'h59);
    if_hi.load = 0;
    check("hi_loaded", {24'd0, if_hi.count}, 32'h59);
    if_hi.en = 1;
    if_a.en = 1; if_a.cin = 1; if_a.clr = 0; if_a.load = 0; if_a.up_dn = 1;
    #1;
    check("hi_co_la", {31'd0, if_hi.co_la}, 32'd1);
    cyc(1, 1, 0, 0, 1, 8'h00);
    check("hi_wrap_count", {24'd0, if_hi.count}, 32'd0);
    check("hi_wrap_cout", {31'd0, if_hi.cout}, 32'd1);
    if_hi.en = 0;
    cyc(0, 0, 0, 0, 1, 8'h00);
    check("hi_cout_pulse", {31'd0, if_hi.cout}, 32'd0);

    // Down direction (counts up when the down mode is not built).
    cyc(0, 0, 0, 1, 1, 8'h01);
    cyc(1, 1, 0, 0, 0, 8'h00);
    cyc(1, 1, 0, 0, 0, 8'h00);

    // Random mix of all controls.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
          1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
